m10k_clkgen: RTL and testbench

- Parametrised, runtime-reconfigurable clock-enable generator; the next generation after the fixed single-output PLL wrapper on the M10K clock domain.
- Derives NUM_CLOCKS fractional-rate enables and square waves from one reference clock using per-channel phase accumulators.
- Provides a lock/settle indication and a valid/ready configuration port, so datapath blocks can change rates without a rebuild.

---
 rtl/m10k_clkgen_pkg.sv | 24 ++
 rtl/m10k_clkgen_chan.sv | 67 ++++++
 rtl/m10k_clkgen.sv | 156 +++++++++++++++
 tb/tb_m10k_clkgen.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m10k_clkgen_pkg.sv
// Shared types and constants for the m10k_clkgen clock-enable generator.
package m10k_clkgen_pkg;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        LOCKED = 2'd1,
        APPLY  = 2'd2
    } state_t;

    localparam int DEF_ACC_W       = 16;
    localparam int DEF_LOCK_CYCLES = 64;

    // Width of a channel index; a single channel still gets a 1-bit select.
    function automatic int chan_w(input int n);
        int w;
        if (n > 1) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/m10k_clkgen_chan.sv
// One phase-accumulator channel: accumulator, increment and stored phase,
// with registered square wave (accumulator MSB) and registered carry pulse.
module m10k_clkgen_chan
    import m10k_clkgen_pkg::*;
#(
    parameter int               ACC_W   = DEF_ACC_W,
    parameter logic [ACC_W-1:0] DEF_INC = {1'b1, {(ACC_W-1){1'b0}}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [ACC_W-1:0] load_inc,
    input  logic [ACC_W-1:0] load_phase,
    input  logic             sync,
    input  logic             en_gate,
    output logic             outclk,
    output logic             outclk_en
);

    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] inc_r;
    logic [ACC_W-1:0] phase_r;
    logic             outclk_r;
    logic             outclk_en_r;
    logic [ACC_W:0]   sum_s;
    logic [ACC_W-1:0] acc_nxt_s;
    logic             carry_s;

    // Next accumulator value: a configuration load beats a resync, which beats
    // the normal add; neither reload produces a carry pulse.
    always_comb begin
        sum_s = {1'b0, acc_r} + {1'b0, inc_r};
        if (load) begin
            acc_nxt_s = load_phase;
            carry_s   = 1'b0;
        end else if (sync) begin
            acc_nxt_s = phase_r;
            carry_s   = 1'b0;
        end else begin
            acc_nxt_s = sum_s[ACC_W-1:0];
            carry_s   = sum_s[ACC_W];
        end
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r       <= {ACC_W{1'b0}};
            inc_r       <= DEF_INC;
            phase_r     <= {ACC_W{1'b0}};
            outclk_r    <= 1'b0;
            outclk_en_r <= 1'b0;
        end else begin
            acc_r       <= acc_nxt_s;
            outclk_r    <= acc_nxt_s[ACC_W-1];
            outclk_en_r <= carry_s & en_gate;
            if (load) begin
                inc_r   <= load_inc;
                phase_r <= load_phase;
            end
        end
    end

    assign outclk    = outclk_r;
    assign outclk_en = outclk_en_r;

endmodule

// File: rtl/m10k_clkgen.sv
// Runtime-reconfigurable NUM_CLOCKS-channel clock-enable generator with lock
// indication. Optional M10K_CLKGEN_SYNC_EN adds a sync_pulse phase-realign input.
module m10k_clkgen
    import m10k_clkgen_pkg::*;
#(
    parameter int               NUM_CLOCKS  = 4,
    parameter int               ACC_W       = DEF_ACC_W,
    parameter int               LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter logic [ACC_W-1:0] DEF_INC     = {1'b1, {(ACC_W-1){1'b0}}}
) (
    input  logic                              refclk,
    input  logic                              rst,
`ifdef M10K_CLKGEN_SYNC_EN
    input  logic                              sync_pulse,
`endif
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [chan_w(NUM_CLOCKS)-1:0]     cfg_chan,
    input  logic [ACC_W-1:0]                  cfg_inc,
    input  logic [ACC_W-1:0]                  cfg_phase,
    output logic [NUM_CLOCKS-1:0]             outclk_en,
    output logic [NUM_CLOCKS-1:0]             outclk,
    output logic                              locked
);

    localparam int               CH_W    = chan_w(NUM_CLOCKS);
    localparam int               CNT_W   = $clog2(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CYCLES - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             locked_r;
    logic             locked_nxt_s;
    logic             ready_r;
    logic             ready_nxt_s;
    logic             accept_s;
    logic             in_range_s;
    logic             capture_s;
    logic [31:0]      chan_ext_s;
    logic [CH_W-1:0]  chan_r;
    logic [ACC_W-1:0] inc_cap_r;
    logic [ACC_W-1:0] phase_cap_r;
    logic             sync_s;

`ifdef M10K_CLKGEN_SYNC_EN
    assign sync_s = sync_pulse;
`else
    assign sync_s = 1'b0;
`endif

    assign chan_ext_s = 32'(cfg_chan);
    assign in_range_s = (chan_ext_s < 32'(NUM_CLOCKS));
    assign accept_s   = cfg_valid && ready_r;

    // Settle/lock sequencing. The first cycle after reset release is the
    // SETTLE entry (ready still low), so it does not advance the counter.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        locked_nxt_s = locked_r;
        capture_s    = 1'b0;
        case (state_r)
            SETTLE: begin
                if (accept_s && in_range_s) begin
                    capture_s   = 1'b1;
                    state_nxt_s = APPLY;
                end else if (ready_r) begin
                    if (cnt_r == CNT_MAX) begin
                        state_nxt_s  = LOCKED;
                        locked_nxt_s = 1'b1;
                        cnt_nxt_s    = {CNT_W{1'b0}};
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            LOCKED: begin
                if (accept_s && in_range_s) begin
                    capture_s   = 1'b1;
                    state_nxt_s = APPLY;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            APPLY: begin
                state_nxt_s  = SETTLE;
                cnt_nxt_s    = {CNT_W{1'b0}};
                locked_nxt_s = 1'b0;
            end
            default: begin
                state_nxt_s  = SETTLE;
                cnt_nxt_s    = {CNT_W{1'b0}};
                locked_nxt_s = 1'b0;
            end
        endcase
        ready_nxt_s = (state_nxt_s != APPLY);
    end

    // FSM, counter, lock and ready registers.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state_r  <= SETTLE;
            cnt_r    <= {CNT_W{1'b0}};
            locked_r <= 1'b0;
            ready_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            locked_r <= locked_nxt_s;
            ready_r  <= ready_nxt_s;
        end
    end

    // Configuration fields held for the APPLY cycle.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            chan_r      <= {CH_W{1'b0}};
            inc_cap_r   <= {ACC_W{1'b0}};
            phase_cap_r <= {ACC_W{1'b0}};
        end else if (capture_s) begin
            chan_r      <= cfg_chan;
            inc_cap_r   <= cfg_inc;
            phase_cap_r <= cfg_phase;
        end
    end

    // Pulses are gated with the lock value being registered this edge so that
    // outclk_en never shows a pulse while locked reads low.
    for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
        logic load_s;
        assign load_s = (state_r == APPLY) && (chan_r == CH_W'(i));

        m10k_clkgen_chan #(
            .ACC_W   (ACC_W),
            .DEF_INC (DEF_INC)
        ) u_chan (
            .clk        (refclk),
            .rst_n      (rst),
            .load       (load_s),
            .load_inc   (inc_cap_r),
            .load_phase (phase_cap_r),
            .sync       (sync_s),
            .en_gate    (locked_nxt_s),
            .outclk     (outclk[i]),
            .outclk_en  (outclk_en[i])
        );
    end

    assign cfg_ready = ready_r;
    assign locked    = locked_r;

endmodule

// File: tb/tb_m10k_clkgen.sv
// Self-checking bench for m10k_clkgen (NUM_CLOCKS=4, ACC_W=16, LOCK_CYCLES=64),
// plus a 3-channel instance for the out-of-range channel index.
`timescale 1ns/1ps
module tb_m10k_clkgen;

    localparam int LOCK_EDGES = 65;  // first edge is the settle entry, then 64 cycles

    logic        refclk = 1'b0;
    logic        rst;
    logic        sync_pulse;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_chan;
    logic [15:0] cfg_inc;
    logic [15:0] cfg_phase;
    logic [3:0]  outclk_en;
    logic [3:0]  outclk;
    logic        locked;

    logic        cfg3_valid;
    logic        cfg3_ready;
    logic [1:0]  cfg3_chan;
    logic [15:0] cfg3_inc;
    logic [15:0] cfg3_phase;
    logic [2:0]  outclk3_en;
    logic [2:0]  outclk3;
    logic        locked3;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [3:0]  last_oc;
    logic [3:0]  last_en;

    typedef struct {
        int          chan;
        logic [15:0] inc;
        logic [15:0] phase;
        bit          align;
        bit          ch0_run;
        int          mode;      // 0: count pulses/high on chan, 1: outclk[2] == ~outclk[0]
        int          window;
        int          pulses;
        int          high;
    } vec_t;

    typedef struct {
        int chan;
        int mode;
        int pulses;
        int high;
    } exp_t;

    vec_t vecs[5];
    exp_t exp_q[$];

    m10k_clkgen #(
        .NUM_CLOCKS  (4),
        .ACC_W       (16),
        .LOCK_CYCLES (64),
        .DEF_INC     (16'h8000)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
`ifdef M10K_CLKGEN_SYNC_EN
        .sync_pulse (sync_pulse),
`endif
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_inc    (cfg_inc),
        .cfg_phase  (cfg_phase),
        .outclk_en  (outclk_en),
        .outclk     (outclk),
        .locked     (locked)
    );

    m10k_clkgen #(
        .NUM_CLOCKS  (3),
        .ACC_W       (16),
        .LOCK_CYCLES (64),
        .DEF_INC     (16'h8000)
    ) dut3 (
        .refclk     (refclk),
        .rst        (rst),
`ifdef M10K_CLKGEN_SYNC_EN
        .sync_pulse (sync_pulse),
`endif
        .cfg_valid  (cfg3_valid),
        .cfg_ready  (cfg3_ready),
        .cfg_chan   (cfg3_chan),
        .cfg_inc    (cfg3_inc),
        .cfg_phase  (cfg3_phase),
        .outclk_en  (outclk3_en),
        .outclk     (outclk3),
        .locked     (locked3)
    );

    always #5 refclk = ~refclk;
    always @(posedge refclk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        last_oc = outclk;
        last_en = outclk_en;
        @(posedge refclk);
        #1;
    endtask

    task automatic measure_lock(input bit chk_ch0, output int n);
        n = -1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (k == 1) begin
                check("locked_low_after_entry", {31'd0, locked}, 32'd0);
                check("cfg_ready_high_after_entry", {31'd0, cfg_ready}, 32'd1);
            end
            if (chk_ch0) check("ch0_free_run", {31'd0, outclk[0]}, {31'd0, 1'(~last_oc[0])});
            if (locked) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic write_cfg(input int chan, input logic [15:0] inc, input logic [15:0] phase,
                             input logic exp_lk, output int acc_cyc);
        for (int w = 0; w < 100 && !cfg_ready; w++) tick();
        if (!cfg_ready) check("cfg_ready_wait", {31'd0, cfg_ready}, 32'd1);
        cfg_valid = 1'b1;
        cfg_chan  = 2'(chan);
        cfg_inc   = inc;
        cfg_phase = phase;
        tick();
        cfg_valid = 1'b0;
        acc_cyc   = cyc;
        check("cfg_ready_low_in_apply", {31'd0, cfg_ready}, 32'd0);
        check("locked_held_in_apply", {31'd0, locked}, {31'd0, exp_lk});
    endtask

    task automatic check_default_pattern(input string tag);
        for (int k = 0; k < 8; k++) begin
            tick();
            check({tag, "_outclk_toggle"}, {28'd0, outclk}, {28'd0, 4'(~last_oc)});
            check({tag, "_en_alternate"}, {28'd0, outclk_en}, {28'd0, 4'(~last_en)});
        end
    endtask

    initial begin
        int   n;
        int   c;
        int   ref_cyc;
        int   pulses;
        int   high;
        int   bad;
        exp_t e;

        vecs[0] = '{1, 16'h4000, 16'h0000, 1'b0, 1'b1, 0, 16,   4,   8};
        vecs[1] = '{0, 16'h3000, 16'h0000, 1'b0, 1'b0, 0, 1024, 192, 512};
        vecs[2] = '{0, 16'h4000, 16'h0000, 1'b0, 1'b0, 0, 16,   4,   8};
        vecs[3] = '{2, 16'h4000, 16'h8000, 1'b1, 1'b0, 1, 32,   0,   0};
        vecs[4] = '{3, 16'h0000, 16'h0000, 1'b0, 1'b0, 0, 64,   0,   0};
        ref_cyc = 0;

        rst        = 1'b1;
        sync_pulse = 1'b0;
        cfg_valid  = 1'b0;
        cfg_chan   = 2'd0;
        cfg_inc    = 16'h0000;
        cfg_phase  = 16'h0000;
        cfg3_valid = 1'b0;
        cfg3_chan  = 2'd0;
        cfg3_inc   = 16'h0000;
        cfg3_phase = 16'h0000;
        #2 rst = 1'b0;
        #1;
        check("rst_outclk", {28'd0, outclk}, 32'd0);
        check("rst_outclk_en", {28'd0, outclk_en}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        repeat (3) @(posedge refclk);
        @(negedge refclk) rst = 1'b1;

        measure_lock(1'b0, n);
        check("first_lock_edge", n, LOCK_EDGES);
        check_default_pattern("default");

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].align) begin
                for (int k = 0; k < 8 && ((cyc - ref_cyc) % 4) != 3; k++) tick();
            end
            write_cfg(vecs[i].chan, vecs[i].inc, vecs[i].phase, 1'b1, c);
            if (vecs[i].chan == 0) ref_cyc = c;
            exp_q.push_back('{vecs[i].chan, vecs[i].mode, vecs[i].pulses, vecs[i].high});

            measure_lock(vecs[i].ch0_run, n);
            check($sformatf("v%0d_relock_edge", i), n, LOCK_EDGES);

            e = exp_q.pop_front();
            pulses = 0;
            high   = 0;
            bad    = 0;
            for (int k = 0; k < vecs[i].window; k++) begin
                tick();
                pulses += int'(outclk_en[e.chan]);
                high   += int'(outclk[e.chan]);
                if (outclk[2] == outclk[0]) bad++;
            end
            if (e.mode == 1) begin
                check($sformatf("v%0d_ch2_inverse_of_ch0", i), bad, 0);
            end else begin
                check($sformatf("v%0d_pulses", i), pulses, e.pulses);
                check($sformatf("v%0d_high_cycles", i), high, e.high);
            end
        end

        // Accept during SETTLE restarts settling from zero.
        write_cfg(1, 16'h4000, 16'h0000, 1'b1, c);
        repeat (20) tick();
        write_cfg(1, 16'h4000, 16'h0000, 1'b0, c);
        measure_lock(1'b0, n);
        check("restart_lock_edge", n, LOCK_EDGES);

        // Out-of-range channel on the 3-channel instance is swallowed.
        check("n3_locked_before", {31'd0, locked3}, 32'd1);
        cfg3_valid = 1'b1;
        cfg3_chan  = 2'd3;
        cfg3_inc   = 16'h1234;
        cfg3_phase = 16'h5678;
        tick();
        cfg3_valid = 1'b0;
        check("n3_ready_after_ignored", {31'd0, cfg3_ready}, 32'd1);
        bad = 0;
        for (int k = 0; k < 70; k++) begin
            tick();
            if (!locked3 || !cfg3_ready) bad++;
        end
        check("n3_stays_locked", bad, 0);

        // Asynchronous reset 20 cycles into SETTLE.
        write_cfg(1, 16'h4000, 16'h0000, 1'b1, c);
        repeat (20) tick();
        #2 rst = 1'b0;
        #1;
        check("midrst_outclk", {28'd0, outclk}, 32'd0);
        check("midrst_outclk_en", {28'd0, outclk_en}, 32'd0);
        check("midrst_locked", {31'd0, locked}, 32'd0);
        check("midrst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        repeat (2) @(negedge refclk);
        rst = 1'b1;
        measure_lock(1'b0, n);
        check("midrst_relock_edge", n, LOCK_EDGES);
        check_default_pattern("post_rst");

`ifdef M10K_CLKGEN_SYNC_EN
        for (int k = 0; k < 2 && outclk != 4'h0; k++) tick();
        sync_pulse = 1'b1;
        tick();
        sync_pulse = 1'b0;
        check("sync_outclk_reload", {28'd0, outclk}, 32'd0);
        check("sync_en_suppressed", {28'd0, outclk_en}, 32'd0);
        check("sync_locked_kept", {31'd0, locked}, 32'd1);
        tick();
        check("sync_next_outclk", {28'd0, outclk}, 32'hF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
